// File: rtl/ata_pio_ctrl.sv
// ata_pio_ctrl: host async bus to ATA PIO bridge with parametrised setup/active/hold/recovery timing.
// Inputs : clk, reset (async, active low), cs5/moe/mwe (host, active low), a[3:0],
//          iordy, intrq, timeout_clr.
// Outputs: cs0/cs1/dior/diow (ATA, active low), da[2:0], rw (0 = device to host),
//          oe (buffer enable, active low), exprdy (host wait, active low), eint, timeout (sticky).
module ata_pio_ctrl #(
    parameter int CW        = 6,
    parameter int T_SETUP   = 2,
    parameter int T_ACTIVE  = 16,
    parameter int T_SAMPLE  = 2,
    parameter int T_RD_HOLD = 2,
    parameter int T_HOLD    = 1,
    parameter int T_RECOVER = 3,
    parameter int T_TIMEOUT = 45
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs5,
    input  logic       moe,
    input  logic       mwe,
    input  logic [3:0] a,
    input  logic       iordy,
    input  logic       intrq,
    input  logic       timeout_clr,
    output logic       cs0,
    output logic       cs1,
    output logic       dior,
    output logic       diow,
    output logic [2:0] da,
    output logic       rw,
    output logic       oe,
    output logic       exprdy,
    output logic       eint,
    output logic       timeout
);
    typedef enum logic [2:0] {IDLE, CMD, SETUP, ACTIVE, WAIT, RDHOLD, HOLD, REC} state_t;
    localparam logic [CW-1:0] C_SETUP   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_SAMPLE  = CW'(T_SAMPLE);
    localparam logic [CW-1:0] C_ACTIVE  = CW'(T_ACTIVE - 1);
    localparam logic [CW-1:0] C_RD_HOLD = CW'(T_RD_HOLD - 1);
    localparam logic [CW-1:0] C_HOLD    = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_RECOVER = CW'(T_RECOVER - 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(T_TIMEOUT - 1);
    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic [2:0] da_d;
    logic cs0_d, cs1_d, dior_d, diow_d, rw_d, exprdy_d, tmo_d, rd, rd_d, fin;
    assign oe   = cs0 & cs1;
    assign eint = !intrq;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cs0     <= 1'b1;
            cs1     <= 1'b1;
            dior    <= 1'b1;
            diow    <= 1'b1;
            da      <= '0;
            rw      <= 1'b1;
            exprdy  <= 1'b1;
            timeout <= 1'b0;
            rd      <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= (state_d != state) ? '0 : cnt + 1'b1;
            cs0     <= cs0_d;
            cs1     <= cs1_d;
            dior    <= dior_d;
            diow    <= diow_d;
            da      <= da_d;
            rw      <= rw_d;
            exprdy  <= exprdy_d;
            timeout <= tmo_d;
            rd      <= rd_d;
        end
    end
    always_comb begin
        state_d  = state;
        cs0_d    = cs0;
        cs1_d    = cs1;
        dior_d   = dior;
        diow_d   = diow;
        da_d     = da;
        rw_d     = rw;
        exprdy_d = exprdy;
        rd_d     = rd;
        tmo_d    = timeout & ~timeout_clr;
        fin      = 1'b0;
        case (state)
            IDLE: if (!cs5) begin
                da_d     = a[2:0];
                cs0_d    = a[3];
                cs1_d    = !a[3];
                exprdy_d = 1'b0;
                state_d  = CMD;
            end
            // read wins when both strobes are low; neither low falls through as a write
            CMD: begin
                rd_d    = !moe;
                rw_d    = moe;
                state_d = SETUP;
            end
            SETUP: if (cnt == C_SETUP) begin
                dior_d  = !rd;
                diow_d  = rd;
                state_d = ACTIVE;
            end
            ACTIVE: if (cnt == C_SAMPLE && !iordy) state_d = WAIT;
                    else if (cnt == C_ACTIVE) fin = 1'b1;
            // leaving with iordy still low can only be the timeout; a simultaneous clear loses
            WAIT: if (iordy || cnt == C_TIMEOUT) begin
                fin   = 1'b1;
                tmo_d = tmo_d | !iordy;
            end
            RDHOLD: if (cnt == C_RD_HOLD) begin
                dior_d  = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (cnt == C_HOLD) begin
                cs0_d   = 1'b1;
                cs1_d   = 1'b1;
                rw_d    = 1'b1;
                state_d = REC;
            end
            REC: if (cnt == C_RECOVER) state_d = IDLE;
        endcase
        // end of the strobe window: release the host; writes drop diow now, reads hold dior a bit longer
        if (fin) begin
            exprdy_d = 1'b1;
            diow_d   = 1'b1;
            state_d  = rd ? RDHOLD : HOLD;
        end
    end
endmodule

// File: tb/tb_ata_pio_ctrl.sv
// tb_ata_pio_ctrl: event-time reference model bench for ata_pio_ctrl.
module tb_ata_pio_ctrl;
    localparam int CW = 6, T_SETUP = 2, T_ACTIVE = 16, T_SAMPLE = 2, T_RD_HOLD = 2;
    localparam int T_HOLD = 1, T_RECOVER = 3, T_TIMEOUT = 45;
    logic clk = 1'b0, reset = 1'b1, cs5 = 1'b1, moe = 1'b1, mwe = 1'b1;
    logic [3:0] a = '0;
    logic iordy = 1'b1, intrq = 1'b0, timeout_clr = 1'b0;
    logic cs0, cs1, dior, diow, rw, oe, exprdy, eint, timeout;
    logic [2:0] da;
    int checks = 0, errors = 0;
    logic tmo_m = 1'b0;
    logic [2:0] da_m = '0;
    bit clr_rand = 1'b0;
    always #5 clk = ~clk;
    ata_pio_ctrl #(.CW(CW), .T_SETUP(T_SETUP), .T_ACTIVE(T_ACTIVE), .T_SAMPLE(T_SAMPLE),
        .T_RD_HOLD(T_RD_HOLD), .T_HOLD(T_HOLD), .T_RECOVER(T_RECOVER), .T_TIMEOUT(T_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cs5(cs5), .moe(moe), .mwe(mwe), .a(a), .iordy(iordy),
        .intrq(intrq), .timeout_clr(timeout_clr), .cs0(cs0), .cs1(cs1), .dior(dior), .diow(diow),
        .da(da), .rw(rw), .oe(oe), .exprdy(exprdy), .eint(eint), .timeout(timeout)
    );
    // vector order: cs0 cs1 dior diow rw oe exprdy timeout eint da[2:0]
    task automatic cmp(input string tag, input int k, input logic e_cs0, e_cs1, e_dior, e_diow, e_rw, e_exprdy);
        logic [11:0] o, e;
        o = {cs0, cs1, dior, diow, rw, oe, exprdy, timeout, eint, da};
        e = {e_cs0, e_cs1, e_dior, e_diow, e_rw, e_cs0 & e_cs1, e_exprdy, tmo_m, !intrq, da_m};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, o, e);
        end
    endtask
    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            cs5 = 1'b1;
            a = 4'($urandom);
            moe = 1'($urandom);
            mwe = 1'($urandom);
            iordy = 1'($urandom);
            intrq = 1'($urandom);
            timeout_clr = clr_rand ? ($urandom % 6 == 0) : clr;
            @(posedge clk);
            if (timeout_clr) tmo_m = 1'b0;
            @(negedge clk);
            cmp("idle", i, 1, 1, 1, 1, 1, 1);
        end
    endtask
    // d < 0: iordy high at the sample; otherwise iordy low at the sample and first high d clocks into the wait
    task automatic txn(input string tag, input bit mo, mw, input logic [3:0] ad, input int d,
                       input int abort_k, input bit hold_cs, input bit clr_x);
        bit rd, tevt, csl;
        int s, w, x, h, ce, e, j;
        rd = !mo;
        s = 1 + T_SETUP;
        w = s + T_SAMPLE + 1;
        x = (d < 0) ? s + T_ACTIVE : w + ((d < T_TIMEOUT - 1) ? d : T_TIMEOUT - 1) + 1;
        tevt = d > T_TIMEOUT - 1;
        h = rd ? x + T_RD_HOLD : x;
        ce = h + T_HOLD;
        e = ce + T_RECOVER;
        for (int k = 0; k <= e; k++) begin
            j = k - 1;
            if (j < 0) begin
                cs5 = 1'b0;
                a = ad;
                moe = mo;
                mwe = mw;
            end else begin
                cs5 = hold_cs ? 1'b0 : 1'($urandom);
                a = 4'($urandom);
                if (j >= 1) begin
                    moe = 1'($urandom);
                    mwe = 1'($urandom);
                end
            end
            iordy = (j == s + T_SAMPLE) ? (d < 0) :
                    (d >= 0 && j >= w && j <= w + d) ? (j == w + d) : 1'($urandom);
            intrq = 1'($urandom);
            timeout_clr = clr_rand ? ($urandom % 6 == 0) : (clr_x && k == x);
            @(posedge clk);
            if (timeout_clr) tmo_m = 1'b0;
            if (k == x && tevt) tmo_m = 1'b1;
            if (k == 0) da_m = ad[2:0];
            if (k == abort_k) begin
                #1 reset = 1'b0;
                #1;
                tmo_m = 1'b0;
                da_m = '0;
                cmp({tag, "/reset"}, k, 1, 1, 1, 1, 1, 1);
                @(negedge clk);
                reset = 1'b1;
                cs5 = 1'b1;
                timeout_clr = 1'b0;
                return;
            end
            @(negedge clk);
            csl = k < ce;
            cmp(tag, k, !(csl && !ad[3]), !(csl && ad[3]), !(rd && k >= s && k < h),
                !(!rd && k >= s && k < x), !(rd && k >= 1 && k < ce), !(k < x));
        end
    endtask
    initial begin
        bit mo, mw;
        int d, r;
        #1 reset = 1'b0;
        #2 cmp("reset", 0, 1, 1, 1, 1, 1, 1);
        @(negedge clk);
        cmp("reset_hold", 1, 1, 1, 1, 1, 1, 1);
        reset = 1'b1;
        idle(3, 0);
        txn("rd_a3", 0, 1, 4'b0011, -1, -1, 0, 0);
        idle(2, 0);
        txn("wr_ae", 1, 0, 4'b1110, -1, -1, 0, 0);
        txn("rd_wait", 0, 1, 4'b0101, 9, -1, 0, 0);
        txn("wr_wait0", 1, 0, 4'b1010, 0, -1, 0, 0);
        txn("rd_tmo", 0, 1, 4'b0001, 1000, -1, 0, 0);
        txn("wr_after_tmo", 1, 0, 4'b1100, -1, -1, 0, 0);
        txn("rd_after_tmo", 0, 1, 4'b0111, -1, -1, 0, 0);
        idle(2, 0);
        idle(1, 1);
        idle(1, 0);
        txn("wr_tmo_clr", 1, 0, 4'b0010, 1000, -1, 0, 1);
        idle(1, 1);
        txn("rd_last_wait", 0, 1, 4'b1011, T_TIMEOUT - 1, -1, 0, 0);
        txn("b2b_first", 1, 0, 4'b0100, -1, -1, 1, 0);
        txn("b2b_both", 0, 0, 4'b0110, -1, -1, 1, 0);
        idle(1, 0);
        txn("abort", 0, 1, 4'b1001, -1, 1 + T_SETUP + 5, 0, 0);
        idle(1, 0);
        txn("post_abort", 1, 0, 4'b1111, -1, -1, 0, 0);
        clr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            mo = 1'($urandom);
            mw = mo ? 1'b0 : 1'($urandom);
            r = $urandom % 4;
            d = (r == 0) ? -1 : (r == 1) ? int'($urandom_range(0, 20)) :
                (r == 2) ? int'($urandom_range(40, 47)) : 1000;
            txn("rand", mo, mw, 4'($urandom), d,
                ($urandom % 10 == 0) ? int'($urandom_range(0, 40)) : -1, 1'($urandom), 0);
            idle(int'($urandom_range(0, 3)), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
